// File: rtl/data_ram_responder_if.sv
// Data-memory port between the single-cycle core and its RAM responder.
// The core drives the address, write data and write strobe; the responder returns read data.
interface data_ram_responder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ram_address;
  logic [WIDTH-1:0] ram_w_data;
  logic             read_write_ram_en;
  logic [WIDTH-1:0] ram_r_data;

  modport master (
    output ram_address,
    output ram_w_data,
    output read_write_ram_en,
    input  ram_r_data
  );

  modport slave (
    input  ram_address,
    input  ram_w_data,
    input  read_write_ram_en,
    output ram_r_data
  );
endinterface

// File: rtl/data_ram_responder.sv
// Word-addressed data RAM plus a small MMIO page (GPIO, optional cycle counter) with a sticky error flag.
// Define MMIO_CYCLE_COUNTER_EN to build the free-running counter at MMIO_BASE+4.
module data_ram_responder #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 256,
  parameter int               GPIO_WIDTH = 8,
  parameter logic [WIDTH-1:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic                  clock,
  input  logic                  reset,
  data_ram_responder_if.slave   bus,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  access_error
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [GPIO_WIDTH-1:0] gpio_reg;
  logic                  error_reg;

  logic          aligned;
  logic          ram_hit;
  logic          gpio_hit;
  logic          valid_hit;
  logic [AW-1:0] word_idx;
  logic          write_en;

  assign aligned  = (bus.ram_address[1:0] == 2'b00);
  // Upper bits must be zero so high addresses never alias onto the RAM.
  assign ram_hit  = aligned && (bus.ram_address[WIDTH-1:AW+2] == '0);
  assign gpio_hit = aligned && (bus.ram_address == MMIO_BASE);
  assign word_idx = bus.ram_address[AW+1:2];
  assign write_en = reset && bus.read_write_ram_en;

`ifdef MMIO_CYCLE_COUNTER_EN
  localparam logic [WIDTH-1:0] CNT_ADDR = MMIO_BASE + WIDTH'(4);

  logic [WIDTH-1:0] cycle_count_reg;
  logic             cnt_hit;

  assign cnt_hit   = aligned && (bus.ram_address == CNT_ADDR);
  assign valid_hit = ram_hit || gpio_hit || cnt_hit;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_count_reg <= '0;
    end else if (bus.read_write_ram_en && cnt_hit) begin
      cycle_count_reg <= bus.ram_w_data;
    end else begin
      cycle_count_reg <= cycle_count_reg + WIDTH'(1);
    end
  end
`else
  assign valid_hit = ram_hit || gpio_hit;
`endif

  // Combinational read path: the single-cycle core consumes data in the same cycle.
  always_comb begin
    bus.ram_r_data = '0;
    if (ram_hit) begin
      bus.ram_r_data = mem[word_idx];
    end else if (gpio_hit) begin
      bus.ram_r_data = WIDTH'(gpio_reg);
`ifdef MMIO_CYCLE_COUNTER_EN
    end else if (cnt_hit) begin
      bus.ram_r_data = cycle_count_reg;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (write_en && ram_hit) begin
      mem[word_idx] <= bus.ram_w_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      gpio_reg  <= '0;
      error_reg <= 1'b0;
    end else begin
      if (bus.read_write_ram_en && gpio_hit) begin
        gpio_reg <= bus.ram_w_data[GPIO_WIDTH-1:0];
      end
      if (!valid_hit) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign gpio_out     = gpio_reg;
  assign access_error = error_reg;
endmodule

// File: tb/tb_data_ram_responder.sv
// Directed self-checking bench for data_ram_responder: RAM, GPIO, bounds, alignment, reset, counter.
module tb_data_ram_responder;
  logic       clock;
  logic       reset;
  logic [7:0] gpio_out;
  logic       access_error;

  int n_compared;
  int n_mismatched;

  data_ram_responder_if #(.WIDTH(32)) bus ();

  data_ram_responder #(
    .WIDTH(32),
    .DEPTH(256),
    .GPIO_WIDTH(8),
    .MMIO_BASE(32'hFFFF_FF00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .gpio_out(gpio_out),
    .access_error(access_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
    $display("check %-16s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    bus.ram_address       = addr;
    bus.ram_w_data        = wdata;
    bus.read_write_ram_en = we;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_err", 32'(access_error), 32'h0);

    // Preload word 0 and word 4 so aliasing and read-during-write are observable.
    drive(32'h0000_0000, 32'hA0A0_A0A0, 1'b1); tick();
    drive(32'h0000_0010, 32'h1111_1111, 1'b1); tick();

    // 1: write then read; same-cycle read shows the old word.
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    check("rdw_old", bus.ram_r_data, 32'h1111_1111);
    tick();
    drive(32'h0000_0010, 32'h0, 1'b0);
    check("rd_0x10", bus.ram_r_data, 32'hDEAD_BEEF);
    tick();

    // 2: last word valid, one past the end is out-of-range and must not alias to word 0.
    drive(32'h0000_03FC, 32'hCAFE_F00D, 1'b1); tick();
    drive(32'h0000_03FC, 32'h0, 1'b0);
    check("rd_last", bus.ram_r_data, 32'hCAFE_F00D);
    tick();
    check("err_last", 32'(access_error), 32'h0);
    drive(32'h0000_0400, 32'h5555_5555, 1'b1);
    check("rd_oor", bus.ram_r_data, 32'h0);
    tick();
    check("err_oor", 32'(access_error), 32'h1);
    drive(32'h0000_0000, 32'h0, 1'b0);
    check("no_alias_w0", bus.ram_r_data, 32'hA0A0_A0A0);
    tick();

    reset = 1'b0; idle(); tick(); reset = 1'b1;
    check("err_clr", 32'(access_error), 32'h0);

    // 3: GPIO write and zero-extended readback.
    drive(32'hFFFF_FF00, 32'h1234_56A5, 1'b1);
    check("gpio_pre", 32'(gpio_out), 32'h0);
    tick();
    check("gpio_out", 32'(gpio_out), 32'h0000_00A5);
    drive(32'hFFFF_FF00, 32'h0, 1'b0);
    check("rd_gpio", bus.ram_r_data, 32'h0000_00A5);
    tick();
    check("err_gpio", 32'(access_error), 32'h0);

    // 4: misaligned read/write, and a high-bit alias of a RAM address.
    drive(32'h0000_0013, 32'h0, 1'b0);
    check("rd_misal", bus.ram_r_data, 32'h0);
    tick();
    check("err_misal", 32'(access_error), 32'h1);
    drive(32'h0000_0013, 32'h9999_9999, 1'b1); tick();
    drive(32'h0001_0010, 32'h7777_7777, 1'b1);
    check("rd_hialias", bus.ram_r_data, 32'h0);
    tick();
    drive(32'h0000_0010, 32'h0, 1'b0);
    check("misal_nowr", bus.ram_r_data, 32'hDEAD_BEEF);
    tick();
    check("err_sticky", 32'(access_error), 32'h1);
    check("gpio_keep", 32'(gpio_out), 32'h0000_00A5);

    // 5: reset with a simultaneous GPIO write; reset wins, RAM survives.
    reset = 1'b0;
    drive(32'hFFFF_FF00, 32'h0000_00FF, 1'b1);
    tick();
    reset = 1'b1;
    idle();
    check("rst_w_gpio", 32'(gpio_out), 32'h0);
    check("rst_w_err", 32'(access_error), 32'h0);
    drive(32'h0000_0010, 32'h0, 1'b0);
    check("ram_kept", bus.ram_r_data, 32'hDEAD_BEEF);
    tick();

    // 6: cycle counter load and wrap, or out-of-range when not built.
    drive(32'hFFFF_FF04, 32'hFFFF_FFFE, 1'b1);
`ifdef MMIO_CYCLE_COUNTER_EN
    tick();
    drive(32'hFFFF_FF04, 32'h0, 1'b0);
    check("cnt_load", bus.ram_r_data, 32'hFFFF_FFFE);
    tick();
    check("cnt_inc", bus.ram_r_data, 32'hFFFF_FFFF);
    tick();
    check("cnt_wrap", bus.ram_r_data, 32'h0);
    check("cnt_err", 32'(access_error), 32'h0);
`else
    check("cnt_rd0", bus.ram_r_data, 32'h0);
    tick();
    idle();
    check("cnt_err", 32'(access_error), 32'h1);
`endif
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
